// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param. The producer/consumer side uses
// the master modport and the FIFO uses the slave modport.
interface sync_fifo_param_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 3
);
  logic [DWIDTH-1:0] Data_In;
  logic              FClrN;
  logic              FInN;
  logic              FOutN;
  logic [DWIDTH-1:0] F_Data;
  logic [AWIDTH:0]   F_Count;
  logic              F_FullN;
  logic              F_EmptyN;
  logic              F_AFullN;
  logic              F_AEmptyN;
  logic              F_OvfN;
  logic              F_UndN;

  modport master (
    output Data_In, FClrN, FInN, FOutN,
    input  F_Data, F_Count, F_FullN, F_EmptyN, F_AFullN, F_AEmptyN, F_OvfN, F_UndN
  );

  modport slave (
    input  Data_In, FClrN, FInN, FOutN,
    output F_Data, F_Count, F_FullN, F_EmptyN, F_AFullN, F_AEmptyN, F_OvfN, F_UndN
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO of arbitrary depth with registered status flags.
// Define SYNC_FIFO_ERRFLAG_EN to build the sticky overflow/underflow flags; otherwise both read 1.
module sync_fifo_param #(
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 6,
  parameter int AWIDTH   = 3,
  parameter int AF_LEVEL = 2,
  parameter int AE_LEVEL = 1
) (
  input  logic               Clk,
  input  logic               RstN,
  sync_fifo_param_if.slave   fifo_if
);

  localparam logic [AWIDTH:0]   DEPTH_CNT   = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   AF_CNT      = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0]   AE_CNT      = (AWIDTH+1)'(AE_LEVEL);
  localparam logic [AWIDTH-1:0] LAST_PTR    = AWIDTH'(DEPTH - 1);
  localparam logic              AFULL_N_RST = (DEPTH > AF_LEVEL);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              empty_n_q, empty_n_d;
  logic              full_n_q, full_n_d;
  logic              afull_n_q, afull_n_d;
  logic              aempty_n_q, aempty_n_d;

  logic wr_req, rd_req, clr, wr_acc, rd_acc;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths use every slot.
  function automatic logic [AWIDTH-1:0] next_ptr(input logic [AWIDTH-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + AWIDTH'(1);
  endfunction

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    wr_req = !fifo_if.FInN;
    rd_req = !fifo_if.FOutN;
    clr    = !fifo_if.FClrN;
    rd_acc = rd_req && (count_q != '0);
    wr_acc = wr_req && ((count_q < DEPTH_CNT) || rd_acc);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
      if (rd_acc) rd_ptr_d = next_ptr(rd_ptr_q);
      if (wr_acc && !rd_acc)      count_d = count_q + (AWIDTH+1)'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - (AWIDTH+1)'(1);
    end
    // Flags come from the next count so they line up with F_Count on the same edge.
    empty_n_d  = (count_d != '0);
    full_n_d   = (count_d != DEPTH_CNT);
    afull_n_d  = ((DEPTH_CNT - count_d) > AF_CNT);
    aempty_n_d = (count_d > AE_CNT);
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_n_q  <= 1'b0;
      full_n_q   <= 1'b1;
      afull_n_q  <= AFULL_N_RST;
      aempty_n_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_n_q  <= empty_n_d;
      full_n_q   <= full_n_d;
      afull_n_q  <= afull_n_d;
      aempty_n_q <= aempty_n_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (wr_acc && !clr) mem_q[wr_ptr_q] <= fifo_if.Data_In;
  end

`ifdef SYNC_FIFO_ERRFLAG_EN
  logic ovf_n_q, ovf_n_d;
  logic und_n_q, und_n_d;

  always_comb begin
    ovf_n_d = ovf_n_q;
    und_n_d = und_n_q;
    if (clr) begin
      ovf_n_d = 1'b1;
      und_n_d = 1'b1;
    end else begin
      if (wr_req && !wr_acc) ovf_n_d = 1'b0;
      if (rd_req && !rd_acc) und_n_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      ovf_n_q <= 1'b1;
      und_n_q <= 1'b1;
    end else begin
      ovf_n_q <= ovf_n_d;
      und_n_q <= und_n_d;
    end
  end

  assign fifo_if.F_OvfN = ovf_n_q;
  assign fifo_if.F_UndN = und_n_q;
`else
  assign fifo_if.F_OvfN = 1'b1;
  assign fifo_if.F_UndN = 1'b1;
`endif

  assign fifo_if.F_Data    = mem_q[rd_ptr_q];
  assign fifo_if.F_Count   = count_q;
  assign fifo_if.F_FullN   = full_n_q;
  assign fifo_if.F_EmptyN  = empty_n_q;
  assign fifo_if.F_AFullN  = afull_n_q;
  assign fifo_if.F_AEmptyN = aempty_n_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: stimulus queues expected words, a negedge monitor
// checks F_Data on every accepted read; status flags are checked against hand-written vectors.
module tb_sync_fifo_param;

  localparam int DWIDTH   = 32;
  localparam int DEPTH    = 6;
  localparam int AWIDTH   = 3;
  localparam int AF_LEVEL = 2;
  localparam int AE_LEVEL = 1;

`ifdef SYNC_FIFO_ERRFLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic Clk  = 1'b0;
  logic RstN = 1'b0;

  int checks = 0;
  int fails  = 0;

  logic [DWIDTH-1:0] exp_q [$];

  // Flag vectors are {F_EmptyN, F_AEmptyN, F_AFullN, F_FullN} for counts 1..6.
  logic [3:0] fill_flags [6] = '{4'b1011, 4'b1111, 4'b1111, 4'b1101, 4'b1101, 4'b1100};

  always #5 Clk = ~Clk;

  sync_fifo_param_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) fifo_if ();

  sync_fifo_param #(
    .DWIDTH(DWIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH),
    .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .Clk(Clk),
    .RstN(RstN),
    .fifo_if(fifo_if)
  );

  // Monitor: a read will be taken at the next edge, so the head word must match the scoreboard.
  always @(negedge Clk) begin
    logic [DWIDTH-1:0] exp_word;
    if (RstN && fifo_if.FClrN && !fifo_if.FOutN && fifo_if.F_EmptyN) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL rd_data: got %h, required no word (scoreboard empty)", fifo_if.F_Data);
      end else begin
        exp_word = exp_q.pop_front();
        if (fifo_if.F_Data !== exp_word) begin
          fails++;
          $display("[TB] FAIL rd_data: got %h, required %h", fifo_if.F_Data, exp_word);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic fin_n, input logic fout_n, input logic clr_n,
                               input logic [DWIDTH-1:0] din, input bit push);
    fifo_if.FInN    = fin_n;
    fifo_if.FOutN   = fout_n;
    fifo_if.FClrN   = clr_n;
    fifo_if.Data_In = din;
    if (push) exp_q.push_back(din);
    @(posedge Clk);
    #1;
    fifo_if.FInN  = 1'b1;
    fifo_if.FOutN = 1'b1;
    fifo_if.FClrN = 1'b1;
  endtask

  task automatic checkOutput(input string name, input int exp_count, input logic [3:0] exp_flags,
                             input logic exp_ovf_n, input logic exp_und_n);
    logic [3:0] got_flags;
    got_flags = {fifo_if.F_EmptyN, fifo_if.F_AEmptyN, fifo_if.F_AFullN, fifo_if.F_FullN};
    checks++;
    if (fifo_if.F_Count !== (AWIDTH+1)'(exp_count)) begin
      fails++;
      $display("[TB] FAIL %s count: got %0d, required %0d", name, fifo_if.F_Count, exp_count);
    end
    checks++;
    if (got_flags !== exp_flags) begin
      fails++;
      $display("[TB] FAIL %s flags{E,AE,AF,F}: got %b, required %b", name, got_flags, exp_flags);
    end
    checks++;
    if (fifo_if.F_OvfN !== exp_ovf_n) begin
      fails++;
      $display("[TB] FAIL %s ovf_n: got %b, required %b", name, fifo_if.F_OvfN, exp_ovf_n);
    end
    checks++;
    if (fifo_if.F_UndN !== exp_und_n) begin
      fails++;
      $display("[TB] FAIL %s und_n: got %b, required %b", name, fifo_if.F_UndN, exp_und_n);
    end
  endtask

  task automatic checkHead(input string name, input logic [DWIDTH-1:0] exp_word);
    checks++;
    if (fifo_if.F_Data !== exp_word) begin
      fails++;
      $display("[TB] FAIL %s head: got %h, required %h", name, fifo_if.F_Data, exp_word);
    end
  endtask

  initial begin
    fifo_if.FInN    = 1'b1;
    fifo_if.FOutN   = 1'b1;
    fifo_if.FClrN   = 1'b1;
    fifo_if.Data_In = '0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset", 0, 4'b0011, 1'b1, 1'b1);
    @(negedge Clk);
    RstN = 1'b1;
    @(posedge Clk);
    #1;

    $display("[TB] fill 0xA0..0xA5");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hA0 + i, 1'b1);
      checkOutput($sformatf("fill%0d", i + 1), i + 1, fill_flags[i], 1'b1, 1'b1);
      checkHead("fill", 32'hA0);
    end

    $display("[TB] drain with wrap");
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0);
    checkOutput("drain1", 5, 4'b1101, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0);
    checkOutput("drain2", 4, 4'b1101, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0);
    checkOutput("drain3", 3, 4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hB0 + i, 1'b1);
      checkOutput($sformatf("drain_rw%0d", i), 3, 4'b1111, 1'b1, 1'b1);
    end
    checkHead("wrap", 32'hB0);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0);
    checkOutput("wrap_rd1", 2, 4'b1111, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0);
    checkOutput("wrap_rd2", 1, 4'b1011, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0);
    checkOutput("wrap_rd3", 0, 4'b0011, 1'b1, 1'b1);

    $display("[TB] full with simultaneous read and write");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h10 + i, 1'b1);
      checkOutput($sformatf("refill%0d", i + 1), i + 1, fill_flags[i], 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hCC, 1'b1);
    checkOutput("full_rw", 6, 4'b1100, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0);
    checkOutput("full_rw_drained", 0, 4'b0011, 1'b1, 1'b1);

    $display("[TB] empty with simultaneous read and write");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h55, 1'b1);
    checkOutput("empty_rw", 1, 4'b1011, 1'b1, ERR_EN ? 1'b0 : 1'b1);
    checkHead("empty_rw", 32'h55);

    $display("[TB] overflow then clear");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 32'h60 + i, 1'b1);
    checkOutput("ovf_fill", 6, 4'b1100, 1'b1, ERR_EN ? 1'b0 : 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h77, 1'b0);
    checkOutput("ovf", 6, 4'b1100, ERR_EN ? 1'b0 : 1'b1, ERR_EN ? 1'b0 : 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
    exp_q.delete();
    checkOutput("clear", 0, 4'b0011, 1'b1, 1'b1);

    $display("[TB] async reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 32'h31 + i, 1'b1);
    checkOutput("pre_reset", 3, 4'b1111, 1'b1, 1'b1);
    #2;
    RstN = 1'b0;
    #1;
    checkOutput("async_reset", 0, 4'b0011, 1'b1, 1'b1);
    exp_q.delete();
    @(negedge Clk);
    RstN = 1'b1;
    @(posedge Clk);
    #1;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h99, 1'b1);
    checkOutput("post_reset_wr", 1, 4'b1011, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, 1'b0);
    checkOutput("post_reset_rd", 0, 4'b0011, 1'b1, 1'b1);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d words left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
